// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//   Owns the RTC multiplexed address/data bus and generates every bus cycle
//   (address phase, data phase, CS/RD/WR/A-D strobes). Two requesters, the
//   periodic refresh reader and the user/programming writer, share the bus
//   through round-robin arbitration.
//
// Optional feature macro: RTC_WR_VERIFY_EN
//   When defined, every write is followed by a read-back of the same address;
//   wr_err flags a mismatch between the read-back and the written data.
//   When undefined, wr_err is constant 0.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   rd_req/rd_addr        read request (level) and register address
//   rd_gnt/rd_done        one-cycle pulses: accepted / rd_data valid
//   rd_data               data returned by the last read
//   wr_req/wr_addr/wr_data write request (level), address, data
//   wr_gnt/wr_done/wr_err one-cycle pulses: accepted / finished / verify fail
//   busy                  high from grant through end of recovery
//   cs_n, rd_n, wr_n, a_d RTC bus strobes (a_d: 0 = address, 1 = data)
//   ad_out, ad_oe, ad_in  AD pad output value, output enable, pad input
//
// Timing note: all bus outputs are decoded from the current state into
// registers, so they appear one cycle after the state is entered. The grant
// pulse is registered from the IDLE arbitration decision, which makes it line
// up with the first ADDR state cycle; the strobes follow one cycle later.
module rtc_bus_sequencer #(
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_IDLE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_gnt,
  output logic       rd_done,
  output logic [7:0] rd_data,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_gnt,
  output logic       wr_done,
  output logic       wr_err,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [7:0] STB_L = 8'(T_STROBE - 1);
  localparam logic [7:0] HLD_L = 8'(T_HOLD - 1);
  localparam logic [7:0] IDL_L = 8'(T_IDLE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AHOLD, S_DATA, S_DHOLD, S_FIN, S_REC
`ifdef RTC_WR_VERIFY_EN
    , S_VADDR, S_VAHOLD, S_VDATA, S_VDHOLD
`endif
  } state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       is_wr_q;
  logic       last_wr_q;     // last served requester, 1 = writer
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       samp_rd_q;     // high during the last RD-low cycle of a read
`ifdef RTC_WR_VERIFY_EN
  logic       samp_vf_q;     // same, for the verify read-back
  logic       err_q;
`endif

  logic       rd_gnt_q, wr_gnt_q, rd_done_q, wr_done_q, wr_err_q, busy_q;
  logic       cs_n_q, rd_n_q, wr_n_q, a_d_q, ad_oe_q;
  logic [7:0] ad_out_q, rd_data_q;

  logic pick_rd, pick_wr, grant_any;

  // On a tie the requester not served last wins.
  assign pick_wr   = wr_req & (~rd_req | ~last_wr_q);
  assign pick_rd   = rd_req & (~wr_req |  last_wr_q);
  assign grant_any = (state_q == S_IDLE) & (rd_req | wr_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'h00;
      is_wr_q   <= 1'b0;
      last_wr_q <= 1'b1;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      samp_rd_q <= 1'b0;
`ifdef RTC_WR_VERIFY_EN
      samp_vf_q <= 1'b0;
      err_q     <= 1'b0;
`endif
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_q     <= 1'b1;
      ad_oe_q   <= 1'b0;
      ad_out_q  <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      busy_q    <= (state_q != S_IDLE) | grant_any;

      // Read data is taken at the end of the last RD-low cycle.
      samp_rd_q <= (state_q == S_DATA) & ~is_wr_q & (cnt_q == 8'h00);
      if (samp_rd_q) rd_data_q <= ad_in;
`ifdef RTC_WR_VERIFY_EN
      samp_vf_q <= (state_q == S_VDATA) & (cnt_q == 8'h00);
      if (samp_vf_q) err_q <= (ad_in != wdata_q);
`endif

      // Registered bus decode of the current state.
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a_d_q   <= 1'b1;
      ad_oe_q <= 1'b0;
      case (state_q)
        S_ADDR: begin
          cs_n_q <= 1'b0; a_d_q <= 1'b0; wr_n_q <= 1'b0;
          ad_oe_q <= 1'b1; ad_out_q <= addr_q;
        end
        S_AHOLD: begin
          cs_n_q <= 1'b0; a_d_q <= 1'b0;
          ad_oe_q <= 1'b1; ad_out_q <= addr_q;
        end
        S_DATA: begin
          cs_n_q <= 1'b0;
          if (is_wr_q) begin
            wr_n_q <= 1'b0; ad_oe_q <= 1'b1; ad_out_q <= wdata_q;
          end else begin
            rd_n_q <= 1'b0;
          end
        end
        S_DHOLD: begin
          cs_n_q <= 1'b0;
          if (is_wr_q) begin
            ad_oe_q <= 1'b1; ad_out_q <= wdata_q;
          end
        end
`ifdef RTC_WR_VERIFY_EN
        S_VADDR: begin
          cs_n_q <= 1'b0; a_d_q <= 1'b0; wr_n_q <= 1'b0;
          ad_oe_q <= 1'b1; ad_out_q <= addr_q;
        end
        S_VAHOLD: begin
          cs_n_q <= 1'b0; a_d_q <= 1'b0;
          ad_oe_q <= 1'b1; ad_out_q <= addr_q;
        end
        S_VDATA:  begin cs_n_q <= 1'b0; rd_n_q <= 1'b0; end
        S_VDHOLD: cs_n_q <= 1'b0;
`endif
        S_FIN: begin
          rd_done_q <= ~is_wr_q;
          wr_done_q <=  is_wr_q;
`ifdef RTC_WR_VERIFY_EN
          wr_err_q  <=  is_wr_q & err_q;
`endif
        end
        default: ;
      endcase

      // Phase sequencing: the counter holds remaining cycles minus one.
      case (state_q)
        S_IDLE: begin
          if (grant_any) begin
            is_wr_q  <= pick_wr;
            rd_gnt_q <= pick_rd;
            wr_gnt_q <= pick_wr;
            addr_q   <= pick_wr ? wr_addr : rd_addr;
            wdata_q  <= wr_data;
            state_q  <= S_ADDR;
            cnt_q    <= STB_L;
          end
        end
        S_FIN: begin
          last_wr_q <= is_wr_q;
`ifdef RTC_WR_VERIFY_EN
          err_q     <= 1'b0;
`endif
          if (T_IDLE == 0) state_q <= S_IDLE;
          else begin state_q <= S_REC; cnt_q <= IDL_L; end
        end
        default: begin
          if (cnt_q != 8'h00) begin
            cnt_q <= cnt_q - 8'h01;
          end else begin
            case (state_q)
              S_ADDR:  begin state_q <= S_AHOLD; cnt_q <= HLD_L; end
              S_AHOLD: begin state_q <= S_DATA;  cnt_q <= STB_L; end
              S_DATA:  begin state_q <= S_DHOLD; cnt_q <= HLD_L; end
`ifdef RTC_WR_VERIFY_EN
              S_DHOLD: begin
                if (is_wr_q) begin state_q <= S_VADDR; cnt_q <= STB_L; end
                else state_q <= S_FIN;
              end
              S_VADDR:  begin state_q <= S_VAHOLD; cnt_q <= HLD_L; end
              S_VAHOLD: begin state_q <= S_VDATA;  cnt_q <= STB_L; end
              S_VDATA:  begin state_q <= S_VDHOLD; cnt_q <= HLD_L; end
              S_VDHOLD: state_q <= S_FIN;
`else
              S_DHOLD: state_q <= S_FIN;
`endif
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign rd_gnt  = rd_gnt_q;
  assign wr_gnt  = wr_gnt_q;
  assign rd_done = rd_done_q;
  assign wr_done = wr_done_q;
  assign wr_err  = wr_err_q;
  assign busy    = busy_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign a_d     = a_d_q;
  assign ad_oe   = ad_oe_q;
  assign ad_out  = ad_out_q;
  assign rd_data = rd_data_q;

endmodule
